// File: rtl/prog_sqr_wav_meas_pkg.sv
// prog_sqr_wav_meas_pkg: FSM state encoding shared by the square-wave measurement block
package prog_sqr_wav_meas_pkg;
  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } meas_state_e;
endpackage

// File: rtl/prog_sqr_wav_meas_sync_edge_det.sv
// prog_sqr_wav_meas_sync_edge_det: 2-flop synchronizer plus delay flop with rise/fall detect
module prog_sqr_wav_meas_sync_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] s_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) s_q <= '0;
    else s_q <= {s_q[1:0], d_i};
  assign lvl_o  = s_q[1];
  assign rise_o = s_q[1] & ~s_q[2];
  assign fall_o = ~s_q[1] & s_q[2];
endmodule

// File: rtl/prog_sqr_wav_meas.sv
// prog_sqr_wav_meas: measures square-wave high/low intervals in TICK_DIV-clock units
module prog_sqr_wav_meas
  import prog_sqr_wav_meas_pkg::*;
#(
  parameter int N        = 4,
  parameter int TICK_DIV = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic         sqr_wav_i,
  output logic [N-1:0] m_o,
  output logic [N-1:0] n_o,
  output logic         meas_valid_o,
  output logic         sat_o,
  output logic         stuck_o
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [N-1:0]  MAX  = '1;
  localparam logic [PW-1:0] HALF = PW'((TICK_DIV + 1) / 2);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic lvl, rise, fall;
  meas_state_e state_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [N-1:0] cnt_q, cnt_d, v, hi_val_q, m_q, n_q;
  logic sat_ph, hi_sat_q, valid_q, sat_q;

  prog_sqr_wav_meas_sync_edge_det u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (sqr_wav_i),
    .lvl_o  (lvl),
    .rise_o (rise),
    .fall_o (fall)
  );

  // rounding only adds one when the count is not already pinned at MAX
  always_comb begin
    sat_ph = cnt_q == MAX;
    v      = sat_ph ? MAX : cnt_q + N'(pre_q >= HALF);
    pre_d  = pre_q == LAST ? '0 : pre_q + PW'(1);
    cnt_d  = pre_q == LAST && !sat_ph ? cnt_q + N'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= SYNC_WAIT;
      pre_q    <= '0;
      cnt_q    <= '0;
      hi_val_q <= '0;
      hi_sat_q <= 1'b0;
      m_q      <= '0;
      n_q      <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
    end else if (!en_i) begin
      state_q  <= SYNC_WAIT;
      pre_q    <= '0;
      cnt_q    <= '0;
      hi_val_q <= '0;
      hi_sat_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == SYNC_WAIT) begin
        if (rise) begin
          state_q <= MEAS_HIGH;
          pre_q   <= PW'(1);
          cnt_q   <= '0;
        end
      end else if (rise | fall) begin
        // the edge cycle is clock 1 of the phase that follows
        state_q <= lvl ? MEAS_HIGH : MEAS_LOW;
        pre_q   <= PW'(1);
        cnt_q   <= '0;
        if (lvl && state_q == MEAS_LOW) begin
          m_q     <= hi_val_q;
          n_q     <= v;
          sat_q   <= hi_sat_q | sat_ph;
          valid_q <= 1'b1;
        end
        if (!lvl) begin
          hi_val_q <= v;
          hi_sat_q <= sat_ph;
        end
      end else begin
        pre_q <= pre_d;
        cnt_q <= cnt_d;
      end
    end

  assign m_o          = m_q;
  assign n_o          = n_q;
  assign meas_valid_o = valid_q;
  assign sat_o        = sat_q;
  assign stuck_o      = state_q != SYNC_WAIT && cnt_q == MAX;
endmodule

// File: tb/tb_prog_sqr_wav_meas.sv
// tb_prog_sqr_wav_meas: scenario tasks checked against an interval-arithmetic reference model
module tb_prog_sqr_wav_meas;
  localparam int N = 4, TD = 5, MAXV = (1 << N) - 1;

  logic clk = 1'b0, reset_n = 1'b0, en_i = 1'b0, sqr_wav_i = 1'b0;
  logic [N-1:0] m_o, n_o;
  logic meas_valid_o, sat_o, stuck_o;
  int vec = 0, err = 0, cyc = 0;
  logic [2*N:0] got_q[$];
  int vt_q[$];

  prog_sqr_wav_meas #(.N(N), .TICK_DIV(TD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en_i        (en_i),
    .sqr_wav_i   (sqr_wav_i),
    .m_o         (m_o),
    .n_o         (n_o),
    .meas_valid_o(meas_valid_o),
    .sat_o       (sat_o),
    .stuck_o     (stuck_o)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (meas_valid_o) begin
      got_q.push_back({sat_o, m_o, n_o});
      vt_q.push_back(cyc);
    end

  function automatic int exp_val(int len);
    int v = len / TD + ((len % TD) >= (TD + 1) / 2 ? 1 : 0);
    return v > MAXV ? MAXV : v;
  endfunction

  function automatic logic [2*N:0] exp_res(int h, int l);
    return {(h / TD >= MAXV) || (l / TD >= MAXV), N'(exp_val(h)), N'(exp_val(l))};
  endfunction

  task automatic drive(input logic v, input int n);
    sqr_wav_i = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic play(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic restart();
    sqr_wav_i = 1'b0;
    en_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    en_i = 1'b1;
    got_q.delete();
    vt_q.delete();
  endtask

  task automatic test_reset();
    en_i = 1'b1;
    sqr_wav_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vec++;
    if ({m_o, n_o} !== '0) begin
      err++;
      $display("FAIL reset_mn: got m=%0d n=%0d want 0 0", m_o, n_o);
    end
    vec++;
    if ({meas_valid_o, sat_o, stuck_o} !== 3'b000) begin
      err++;
      $display("FAIL reset_flags: got valid/sat/stuck=%b want 000", {meas_valid_o, sat_o, stuck_o});
    end
    sqr_wav_i = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [2*N:0] e;
    restart();
    drive(1'b0, 10);
    for (int i = 0; i < 4; i++) play(15, 25);
    drive(1'b1, 5);
    e = exp_res(15, 25);
    vec++;
    if (got_q.size() !== 4) begin
      err++;
      $display("FAIL basic_count: got %0d results want 4", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      vec++;
      if (got_q[i] !== e) begin
        err++;
        $display("FAIL basic_res[%0d]: got %h want %h", i, got_q[i], e);
      end
    end
    for (int i = 1; i < vt_q.size(); i++) begin
      vec++;
      if (vt_q[i] - vt_q[i-1] !== 40) begin
        err++;
        $display("FAIL basic_spacing[%0d]: got %0d clk want 40", i, vt_q[i] - vt_q[i-1]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [2*N:0] e[2];
    restart();
    drive(1'b0, 6);
    play(12, 13);
    play(2, 3);
    drive(1'b1, 5);
    e[0] = exp_res(12, 13);
    e[1] = exp_res(2, 3);
    vec++;
    if (got_q.size() !== 2) begin
      err++;
      $display("FAIL round_count: got %0d results want 2", got_q.size());
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      vec++;
      if (got_q[i] !== e[i]) begin
        err++;
        $display("FAIL round_res[%0d]: got %h want %h", i, got_q[i], e[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [2*N:0] e;
    restart();
    drive(1'b0, 6);
    sqr_wav_i = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (i >= 70) begin
        vec++;
        if (stuck_o !== (i >= 77)) begin
          err++;
          $display("FAIL stuck_rise@%0d: got %b want %b", i, stuck_o, i >= 77);
        end
      end
    end
    sqr_wav_i = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk);
      #1;
      if (j <= 5) begin
        vec++;
        if (stuck_o !== (j < 3)) begin
          err++;
          $display("FAIL stuck_fall@%0d: got %b want %b", j, stuck_o, j < 3);
        end
      end
    end
    drive(1'b1, 5);
    e = exp_res(100, 10);
    vec++;
    if (got_q.size() !== 1 || got_q[0] !== e) begin
      err++;
      $display("FAIL sat_res: got n=%0d first=%h want 1 %h", got_q.size(), got_q[0], e);
    end
  endtask

  task automatic test_latency();
    logic [2*N:0] e;
    reset_n = 1'b0;
    en_i = 1'b1;
    sqr_wav_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    got_q.delete();
    repeat (20) @(posedge clk);
    #1;
    drive(1'b0, 15);
    vec++;
    if (got_q.size() !== 0) begin
      err++;
      $display("FAIL lat_early: got %0d results want 0", got_q.size());
    end
    sqr_wav_i = 1'b1;
    e = exp_res(20, 15);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      vec++;
      if (meas_valid_o !== (i == 3)) begin
        err++;
        $display("FAIL lat_valid@%0d: got %b want %b", i, meas_valid_o, i == 3);
      end
    end
    vec++;
    if ({sat_o, m_o, n_o} !== e) begin
      err++;
      $display("FAIL lat_res: got %h want %h", {sat_o, m_o, n_o}, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [2*N:0] e;
    restart();
    drive(1'b0, 6);
    play(15, 25);
    drive(1'b1, 10);
    drive(1'b0, 8);
    e = exp_res(15, 25);
    vec++;
    if ({sat_o, m_o, n_o} !== e) begin
      err++;
      $display("FAIL rmid_before: got %h want %h", {sat_o, m_o, n_o}, e);
    end
    #3 reset_n = 1'b0;
    #1;
    vec++;
    if ({sat_o, m_o, n_o, meas_valid_o, stuck_o} !== '0) begin
      err++;
      $display("FAIL rmid_async: got %h want 0", {sat_o, m_o, n_o, meas_valid_o, stuck_o});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    drive(1'b0, 5);
    play(10, 20);
    vec++;
    if (got_q.size() !== 0) begin
      err++;
      $display("FAIL rmid_early: got %0d results want 0", got_q.size());
    end
    drive(1'b1, 5);
    e = exp_res(10, 20);
    vec++;
    if (got_q.size() !== 1 || got_q[0] !== e) begin
      err++;
      $display("FAIL rmid_res: got n=%0d first=%h want 1 %h", got_q.size(), got_q[0], e);
    end
  endtask

  task automatic test_enable_drop();
    logic [2*N:0] e0, e1;
    restart();
    drive(1'b0, 6);
    play(15, 25);
    drive(1'b1, 8);
    e0 = exp_res(15, 25);
    en_i = 1'b0;
    drive(1'b1, 20);
    vec++;
    if (got_q.size() !== 1) begin
      err++;
      $display("FAIL en_count: got %0d results want 1", got_q.size());
    end
    vec++;
    if ({sat_o, m_o, n_o} !== e0) begin
      err++;
      $display("FAIL en_hold: got %h want %h", {sat_o, m_o, n_o}, e0);
    end
    en_i = 1'b1;
    drive(1'b1, 7);
    drive(1'b0, 20);
    play(20, 20);
    drive(1'b1, 5);
    e1 = exp_res(20, 20);
    vec++;
    if (got_q.size() !== 2 || got_q[1] !== e1) begin
      err++;
      $display("FAIL en_resume: got n=%0d last=%h want 2 %h", got_q.size(), got_q[got_q.size()-1], e1);
    end
  endtask

  task automatic test_random();
    logic [2*N:0] exp_q[$];
    int h, l;
    restart();
    drive(1'b0, 6);
    for (int i = 0; i < 12; i++) begin
      h = $urandom_range(3, 90);
      l = $urandom_range(3, 90);
      play(h, l);
      exp_q.push_back(exp_res(h, l));
    end
    drive(1'b1, 5);
    vec++;
    if (got_q.size() !== exp_q.size()) begin
      err++;
      $display("FAIL rand_count: got %0d results want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vec++;
      if (got_q[i] !== exp_q[i]) begin
        err++;
        $display("FAIL rand_res[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_latency();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
